// File: rtl/mdu_if.sv
// Request/response bundle between the core and the RV64M multiply/divide unit.
interface mdu_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            is_word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            kill;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, is_word, src1, src2, kill,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, is_word, src1, src2, kill,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mdu.sv
// Iterative RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Define MDU_FAST_MUL_EN for a single-cycle array multiplier; divide is unchanged.
module mdu #(
    parameter int XLEN = 64
) (
    input logic clk,
    input logic rst,
    mdu_if.slave bus
);
    localparam int PW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN64 = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN32 = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic [2:0]      op_q;
    logic            w_q, sg_q, n1_q;
    logic [5:0]      cnt;
    logic [PW-1:0]   acc, mc;
    logic [XLEN-1:0] mp, res_q;

    logic            dv, s1s, s2s, w, n1, n2, dz, ovf, spec, fast;
    logic            accept, last, ge;
    logic [XLEN-1:0] x1, x2, mag1, mag2, spec_v;
    logic [PW-1:0]   fast_prod, acc_nx, mc_nx;
    logic [XLEN-1:0] mp_nx, rem_n;
    logic [XLEN:0]   rem_sh;

    // Sign-correct the raw magnitude result and apply word extension.
    function automatic logic [XLEN-1:0] fin(
        input logic [2:0]      o,
        input logic            wd,
        input logic            sg,
        input logic            n1f,
        input logic [PW-1:0]   pr,
        input logic [XLEN-1:0] qu,
        input logic [XLEN-1:0] rm
    );
        logic [PW-1:0]   p;
        logic [XLEN-1:0] v;
        p = sg ? -pr : pr;
        if (o[2])
            v = o[1] ? (n1f ? -rm : rm) : (sg ? -qu : qu);
        else if (o[1:0] != 2'b00)
            v = p[PW-1:XLEN];
        else
            v = p[XLEN-1:0];
        return wd ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        dv   = bus.op[2];
        s1s  = dv ? !bus.op[0] : (bus.op != 3'b011);
        s2s  = dv ? !bus.op[0] : !bus.op[1];
        w    = bus.is_word & (dv | (bus.op[1:0] == 2'b00));
        x1   = w ? {{(XLEN-32){s1s & bus.src1[31]}}, bus.src1[31:0]}
                 : bus.src1;
        x2   = w ? {{(XLEN-32){s2s & bus.src2[31]}}, bus.src2[31:0]}
                 : bus.src2;
        n1   = s1s & x1[XLEN-1];
        n2   = s2s & x2[XLEN-1];
        mag1 = n1 ? -x1 : x1;
        mag2 = n2 ? -x2 : x2;
        dz   = dv & (x2 == '0);
        ovf  = dv & s1s & (x2 == '1) & (x1 == (w ? MIN32 : MIN64));
        spec = dz | ovf;
        spec_v = bus.op[1] ? (dz ? x1 : '0) : (dz ? '1 : x1);
    end

`ifdef MDU_FAST_MUL_EN
    assign fast      = !bus.op[2];
    assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`else
    assign fast      = 1'b0;
    assign fast_prod = '0;
`endif

    always_comb begin
        rem_sh = {acc[XLEN-1:0], mp[XLEN-1]};
        ge     = rem_sh >= {1'b0, mc[XLEN-1:0]};
        rem_n  = ge ? rem_sh[XLEN-1:0] - mc[XLEN-1:0]
                    : rem_sh[XLEN-1:0];
        if (op_q[2]) begin
            acc_nx = {{XLEN{1'b0}}, rem_n};
            mc_nx  = mc;
            mp_nx  = {mp[XLEN-2:0], ge};
        end else begin
            acc_nx = acc + (mp[0] ? mc : '0);
            mc_nx  = mc << 1;
            mp_nx  = mp >> 1;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid && !bus.kill) begin
                    accept   = 1'b1;
                    state_nx = (spec || fast) ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.kill)
                    state_nx = IDLE;
                else if (cnt == '0)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        last = (state == CALC) && !bus.kill && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            res_q <= '0;
            acc   <= '0;
            mc    <= '0;
            mp    <= '0;
            op_q  <= '0;
            w_q   <= 1'b0;
            sg_q  <= 1'b0;
            n1_q  <= 1'b0;
        end else if (accept) begin
            op_q <= bus.op;
            w_q  <= w;
            sg_q <= n1 ^ n2;
            n1_q <= n1;
            cnt  <= w ? 6'd31 : 6'(XLEN - 1);
            acc  <= '0;
            if (dv) begin
                mc <= {{XLEN{1'b0}}, mag2};
                mp <= w ? {mag1[31:0], {(XLEN-32){1'b0}}} : mag1;
            end else begin
                mc <= {{XLEN{1'b0}}, mag1};
                mp <= mag2;
            end
            if (spec)
                res_q <= spec_v;
            else if (fast)
                res_q <= fin(bus.op, w, n1 ^ n2, n1, fast_prod, '0, '0);
        end else if (state == CALC) begin
            if (cnt != '0)
                cnt <= cnt - 6'd1;
            acc <= acc_nx;
            mc  <= mc_nx;
            mp  <= mp_nx;
            if (last)
                res_q <= fin(op_q, w_q, sg_q, n1_q, acc_nx,
                             mp_nx, acc_nx[XLEN-1:0]);
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
endmodule

// File: tb/tb_mdu.sv
// Directed testbench for mdu: results, latency, kill and reset abort.
module tb_mdu;
    localparam int XLEN = 64;
`ifdef MDU_FAST_MUL_EN
    localparam int ML = 1;
    localparam int MWL = 1;
`else
    localparam int ML = 65;
    localparam int MWL = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mdu_if #(.XLEN(XLEN)) bus ();

    mdu #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.is_word  = w;
        bus.src1     = a;
        bus.src2     = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_r,
                       input int exp_lat);
        int   lat;
        logic bz, rdy;
        lat = 0;
        bz  = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        drive(o, w, a, b);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bz  = bus.busy;
                rdy = bus.in_ready;
            end
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, " lat"}, 64'(lat), 64'(exp_lat));
        check({tag, " res"}, bus.result, exp_r);
        check({tag, " busy"}, {63'b0, bz}, 64'd1);
        check({tag, " rdy"}, {63'b0, rdy}, 64'd0);
    endtask

    // Start a DIVU and abort it in cycle 10 with kill or rst.
    task automatic abort(input string tag, input logic use_rst,
                         input logic [63:0] exp_r);
        logic ov;
        ov = 1'b0;
        @(negedge clk);
        drive(3'b101, 1'b0, 64'd100, 64'd7);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            ov = ov | bus.out_valid;
            if (c == 10) begin
                if (use_rst)
                    rst = 1'b1;
                else
                    bus.kill = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.kill = 1'b0;
        check({tag, " ov"}, {63'b0, ov | bus.out_valid}, 64'd0);
        check({tag, " rdy"}, {63'b0, bus.in_ready}, 64'd1);
        check({tag, " busy"}, {63'b0, bus.busy}, 64'd0);
        check({tag, " res"}, bus.result, exp_r);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.kill     = 1'b0;
        bus.op       = 3'b000;
        bus.is_word  = 1'b0;
        bus.src1     = 64'd3;
        bus.src2     = 64'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst rdy", {63'b0, bus.in_ready}, 64'd1);
        check("rst busy", {63'b0, bus.busy}, 64'd0);
        check("rst ov", {63'b0, bus.out_valid}, 64'd0);
        check("rst res", bus.result, 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run("mul", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
            64'hFFFF_FFFF_FFFF_FFEB, ML);
        run("mulhu", 3'b011, 1'b0, '1, '1,
            64'hFFFF_FFFF_FFFF_FFFE, ML);
        run("mulhsu", 3'b010, 1'b0, '1, 64'd2, '1, ML);
        run("mulh_w", 3'b001, 1'b1, 64'h100_0000_0000,
            64'h100_0000_0000, 64'h1_0000, ML);
        run("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFE, MWL);
        run("div", 3'b100, 1'b0, -64'sd7, 64'd2, -64'sd3, 65);
        run("rem", 3'b110, 1'b0, -64'sd7, 64'd2, '1, 65);
        run("divu0", 3'b101, 1'b0, 64'd5, 64'd0, '1, 1);
        run("divovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1,
            64'h8000_0000_0000_0000, 1);
        run("divw", 3'b100, 1'b1, 64'h1_8000_0000, '1,
            64'hFFFF_FFFF_8000_0000, 1);
        run("remuw", 3'b111, 1'b1, 64'hFFFF_FFFF, 64'd10, 64'd5, 33);
        run("remw", 3'b110, 1'b1, 64'hFFFF_FFF9, 64'd2, '1, 33);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.kill     = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        check("killreq busy", {63'b0, bus.busy}, 64'd0);

        abort("kill", 1'b0, '1);
        run("mul_k", 3'b000, 1'b0, 64'd6, 64'd7, 64'd42, ML);
        abort("rsta", 1'b1, 64'd0);
        run("mul_r", 3'b011, 1'b0, 64'd9, 64'd9, 64'd0, ML);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
